// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - opcodes, state encoding and datapath select codes for the multicycle control unit
package mc_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LI  = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_FETCH = 5'd1,
        S_DECODE = 5'd2,
        S_ALU = 5'd3,
        S_ADI = 5'd4,
        S_LI = 5'd5,
        S_ADDR = 5'd6,
        S_LW = 5'd7,
        S_SW = 5'd8,
        S_MINIT = 5'd9,
        S_LM = 5'd10,
        S_SM = 5'd11,
        S_BEQ = 5'd12,
        S_BTAKE = 5'd13,
        S_LINK = 5'd14,
        S_JAL = 5'd15,
        S_JLR = 5'd16,
        S_HALT = 5'd17
    } state_t;

    localparam logic [1:0] IORD_RFA  = 2'd0;
    localparam logic [1:0] IORD_REGA = 2'd1;
    localparam logic [1:0] IORD_ALU  = 2'd3;

    localparam logic [1:0] RPC_IR86  = 2'd0;
    localparam logic [1:0] RPC_IR53  = 2'd1;
    localparam logic [1:0] RPC_IR119 = 2'd2;
    localparam logic [1:0] RPC_R7    = 2'd3;

    localparam logic [1:0] BC_IR53  = 2'd0;
    localparam logic [1:0] BC_IR86  = 2'd1;
    localparam logic [1:0] BC_CADD  = 2'd2;
    localparam logic [1:0] BC_IR119 = 2'd3;

    localparam logic [1:0] DST_IR53  = 2'd0;
    localparam logic [1:0] DST_IR119 = 2'd1;
    localparam logic [1:0] DST_R7    = 2'd2;
    localparam logic [1:0] DST_CADD  = 2'd3;

    localparam logic [1:0] M2R_MEM = 2'd0;
    localparam logic [1:0] M2R_ALU = 2'd2;
    localparam logic [1:0] M2R_SE9 = 2'd3;

    localparam logic [1:0] SRCB_RFB  = 2'd0;
    localparam logic [1:0] SRCB_SE6  = 2'd1;
    localparam logic [1:0] SRCB_CADD = 2'd2;
    localparam logic [1:0] SRCB_ONE  = 2'd3;

    localparam logic SRCA_REGA = 1'b0;
    localparam logic SRCA_RFA  = 1'b1;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_NDU);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control/status bundle between the control FSM and the datapath
interface mc_control_fsm_if;
    logic [15:0] instr;
    logic        zero;
    logic [1:0]  flagreg;
    logic        out_en;

    logic        IrWrite;
    logic        RegWrite;
    logic        ccr_update;
    logic        aluSrca;
    logic        regA_in;
    logic        enbl;
    logic        mem_wr;
    logic [1:0]  IorD;
    logic [1:0]  R_pc;
    logic [1:0]  B_C;
    logic [1:0]  RegDst;
    logic [1:0]  MemtoReg;
    logic [1:0]  aluScrb;
    logic [1:0]  Aluop;
    logic        illegal_op;
    logic [4:0]  state_dbg;

    modport master (
        input  instr, zero, flagreg, out_en,
        output IrWrite, RegWrite, ccr_update, aluSrca, regA_in, enbl, mem_wr,
        output IorD, R_pc, B_C, RegDst, MemtoReg, aluScrb, Aluop,
        output illegal_op, state_dbg
    );

    modport slave (
        output instr, zero, flagreg, out_en,
        input  IrWrite, RegWrite, ccr_update, aluSrca, regA_in, enbl, mem_wr,
        input  IorD, R_pc, B_C, RegDst, MemtoReg, aluScrb, Aluop,
        input  illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_control_fsm_cond_check.sv
// rtl/mc_control_fsm_cond_check.sv - R-type conditional execute from cz field and latched flags
module mc_cond_check (
    input  logic [1:0] cz,
    input  logic [1:0] flags,
    output logic       exec
);
    // flags[1] = carry/overflow, flags[0] = zero
    assign exec = (cz == 2'b00) | ((cz == 2'b10) & flags[1]) | ((cz == 2'b01) & flags[0]);
endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control unit driving datapath selects, enables and memory strobe
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RESET_IDLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    mc_control_fsm_if.master bus
);

    localparam logic [1:0] IDLE_LAST = 2'(RESET_IDLE_CYCLES - 1);

    state_t     state, next_state;
    logic [1:0] idle_cnt;
    logic       illegal_q;
    logic       exec;
    logic [3:0] opcode;
    logic       unused_instr;

    assign opcode       = bus.instr[15:12];
    assign unused_instr = ^bus.instr[11:2];

    mc_cond_check u_cond (
        .cz    (bus.instr[1:0]),
        .flags (bus.flagreg),
        .exec  (exec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            idle_cnt  <= 2'd0;
            illegal_q <= 1'b0;
        end else begin
            state    <= next_state;
            idle_cnt <= (state == S_RESET) ? idle_cnt + 2'd1 : 2'd0;
            if (next_state == S_HALT)
                illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
    assign bus.state_dbg  = state;

    always_comb begin
        next_state     = state;
        bus.IrWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ccr_update = 1'b0;
        bus.aluSrca    = SRCA_REGA;
        bus.regA_in    = 1'b0;
        bus.enbl       = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.IorD       = IORD_RFA;
        bus.R_pc       = RPC_IR86;
        bus.B_C        = BC_IR53;
        bus.RegDst     = DST_IR53;
        bus.MemtoReg   = M2R_MEM;
        bus.aluScrb    = SRCB_RFB;
        bus.Aluop      = ALU_ADD;

        case (state)
            S_RESET: begin
                if (idle_cnt == IDLE_LAST)
                    next_state = S_FETCH;
            end
            S_FETCH: begin
                bus.R_pc    = RPC_R7;
                bus.IorD    = IORD_RFA;
                bus.IrWrite = 1'b1;
                next_state  = S_DECODE;
            end
            S_DECODE: begin
                bus.R_pc     = RPC_R7;
                bus.aluSrca  = SRCA_RFA;
                bus.aluScrb  = SRCB_ONE;
                bus.RegDst   = DST_R7;
                bus.MemtoReg = M2R_ALU;
                bus.RegWrite = 1'b1;
                case (opcode)
                    OP_ADD, OP_NDU: next_state = (bus.instr[1:0] == 2'b11) ? S_HALT : S_ALU;
                    OP_ADI:         next_state = S_ADI;
                    OP_LI:          next_state = S_LI;
                    OP_LW, OP_SW:   next_state = S_ADDR;
                    OP_LM, OP_SM:   next_state = S_MINIT;
                    OP_BEQ:         next_state = S_BEQ;
                    OP_JAL, OP_JLR: next_state = S_LINK;
                    default:        next_state = S_HALT;
                endcase
            end
            S_ALU: begin
                bus.R_pc       = RPC_IR119;
                bus.B_C        = BC_IR86;
                bus.aluSrca    = SRCA_RFA;
                bus.aluScrb    = SRCB_RFB;
                bus.RegDst     = DST_IR53;
                bus.MemtoReg   = M2R_ALU;
                bus.Aluop      = (opcode == OP_NDU) ? ALU_NAND : ALU_ADD;
                bus.RegWrite   = exec;
                bus.ccr_update = exec;
                next_state     = S_FETCH;
            end
            S_ADI: begin
                bus.R_pc       = RPC_IR86;
                bus.aluSrca    = SRCA_RFA;
                bus.aluScrb    = SRCB_SE6;
                bus.RegDst     = DST_IR119;
                bus.MemtoReg   = M2R_ALU;
                bus.RegWrite   = 1'b1;
                bus.ccr_update = 1'b1;
                next_state     = S_FETCH;
            end
            S_LI: begin
                bus.RegDst   = DST_IR119;
                bus.MemtoReg = M2R_SE9;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_ADDR: begin
                bus.R_pc    = RPC_IR86;
                bus.aluSrca = SRCA_RFA;
                bus.aluScrb = SRCB_SE6;
                bus.regA_in = 1'b1;
                next_state  = (opcode == OP_LW) ? S_LW : S_SW;
            end
            S_LW: begin
                bus.IorD     = IORD_REGA;
                bus.RegDst   = DST_IR119;
                bus.MemtoReg = M2R_MEM;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_SW: begin
                bus.IorD   = IORD_REGA;
                bus.B_C    = BC_IR119;
                bus.mem_wr = 1'b1;
                next_state = S_FETCH;
            end
            S_MINIT: begin
                // regA_in=0 routes RF port A (the base register) straight into regA
                bus.R_pc    = RPC_IR119;
                bus.regA_in = 1'b0;
                bus.enbl    = 1'b1;
                next_state  = (opcode == OP_LM) ? S_LM : S_SM;
            end
            S_LM, S_SM: begin
                next_state = S_FETCH;
                if (bus.out_en) begin
                    bus.IorD    = IORD_REGA;
                    bus.aluSrca = SRCA_REGA;
                    bus.aluScrb = SRCB_ONE;
                    bus.Aluop   = ALU_ADD;
                    bus.regA_in = 1'b1;
                    bus.enbl    = 1'b1;
                    if (state == S_LM) begin
                        bus.RegDst   = DST_CADD;
                        bus.MemtoReg = M2R_MEM;
                        bus.RegWrite = 1'b1;
                    end else begin
                        bus.B_C    = BC_CADD;
                        bus.mem_wr = 1'b1;
                    end
                    next_state = state;
                end
            end
            S_BEQ: begin
                bus.R_pc    = RPC_IR119;
                bus.B_C     = BC_IR86;
                bus.aluSrca = SRCA_RFA;
                bus.aluScrb = SRCB_RFB;
                bus.Aluop   = ALU_SUB;
                next_state  = bus.zero ? S_BTAKE : S_FETCH;
            end
            S_BTAKE: begin
                bus.R_pc     = RPC_R7;
                bus.aluSrca  = SRCA_RFA;
                bus.aluScrb  = SRCB_SE6;
                bus.RegDst   = DST_R7;
                bus.MemtoReg = M2R_ALU;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_LINK: begin
                bus.R_pc     = RPC_R7;
                bus.aluSrca  = SRCA_RFA;
                bus.Aluop    = ALU_PASS;
                bus.RegDst   = DST_IR119;
                bus.MemtoReg = M2R_ALU;
                bus.RegWrite = 1'b1;
                next_state   = (opcode == OP_JAL) ? S_JAL : S_JLR;
            end
            S_JAL: begin
                // Jump write lands after the link write, so it wins when IR[11:9]==7
                bus.RegDst   = DST_R7;
                bus.MemtoReg = M2R_SE9;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_JLR: begin
                bus.R_pc     = RPC_IR86;
                bus.aluSrca  = SRCA_RFA;
                bus.Aluop    = ALU_PASS;
                bus.RegDst   = DST_R7;
                bus.MemtoReg = M2R_ALU;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

    localparam logic [4:0] ST_RESET = 5'd0, ST_FETCH = 5'd1, ST_DECODE = 5'd2, ST_ALU = 5'd3;
    localparam logic [4:0] ST_ADDR = 5'd6, ST_SW = 5'd8, ST_MINIT = 5'd9, ST_LM = 5'd10;
    localparam logic [4:0] ST_SM = 5'd11, ST_BEQ = 5'd12, ST_BTAKE = 5'd13, ST_LINK = 5'd14;
    localparam logic [4:0] ST_JAL = 5'd15, ST_HALT = 5'd17;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.RESET_IDLE_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] all_outs();
        return {bus.IrWrite, bus.RegWrite, bus.ccr_update, bus.aluSrca, bus.regA_in, bus.enbl,
                bus.mem_wr, bus.IorD, bus.R_pc, bus.B_C, bus.RegDst, bus.MemtoReg, bus.aluScrb,
                bus.Aluop, bus.illegal_op};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr = 16'h0000; bus.zero = 1'b0; bus.flagreg = 2'b00; bus.out_en = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_RESET) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_RESET); end
        n_checks++; if (all_outs() !== 20'h0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL first_fetch: got %0d want %0d", bus.state_dbg, ST_FETCH); end
        n_checks++; if ({bus.IrWrite, bus.R_pc, bus.IorD} !== {1'b1, 2'd3, 2'd0}) begin n_fail++; $display("FAIL fetch_outs: got %b want 11100", {bus.IrWrite, bus.R_pc, bus.IorD}); end
    endtask

    task automatic test_add();
        bus.instr = 16'h0A50; bus.flagreg = 2'b00;
        @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.aluScrb} !== {ST_DECODE, 1'b1, 2'd2, 2'd2, 2'd3}) begin n_fail++; $display("FAIL decode_pc_inc: got %h", {bus.state_dbg, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.aluScrb}); end
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_ALU) begin n_fail++; $display("FAIL add_state: got %0d want %0d", bus.state_dbg, ST_ALU); end
        n_checks++; if ({bus.RegWrite, bus.ccr_update, bus.RegDst, bus.Aluop, bus.R_pc, bus.B_C} !== {1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 2'd1}) begin n_fail++; $display("FAIL add_outs: got %b", {bus.RegWrite, bus.ccr_update, bus.RegDst, bus.Aluop, bus.R_pc, bus.B_C}); end
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL add_return: got %0d want %0d", bus.state_dbg, ST_FETCH); end
    endtask

    task automatic test_cond();
        bus.instr = 16'h0A52; bus.flagreg = 2'b00;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.RegWrite, bus.ccr_update} !== 2'b00) begin n_fail++; $display("FAIL adc_noexec: got %b want 00", {bus.RegWrite, bus.ccr_update}); end
        @(negedge clk);
        bus.flagreg = 2'b10;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.RegWrite, bus.ccr_update} !== 2'b11) begin n_fail++; $display("FAIL adc_exec: got %b want 11", {bus.RegWrite, bus.ccr_update}); end
        @(negedge clk);
        bus.instr = 16'h2A51; bus.flagreg = 2'b01;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.RegWrite, bus.Aluop} !== 3'b101) begin n_fail++; $display("FAIL ndz_exec: got %b want 101", {bus.RegWrite, bus.Aluop}); end
        @(negedge clk);
    endtask

    task automatic test_lm();
        int pulses = 0;
        bus.instr = 16'h6205; bus.out_en = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.enbl, bus.R_pc, bus.regA_in} !== {ST_MINIT, 1'b1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL minit_outs: got %h", {bus.state_dbg, bus.enbl, bus.R_pc, bus.regA_in}); end
        bus.out_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.state_dbg == ST_LM && bus.RegWrite && bus.RegDst == 2'd3 && bus.MemtoReg == 2'd0 && bus.IorD == 2'd1)
                pulses++;
        end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL lm_pulses: got %0d want 2", pulses); end
        bus.out_en = 1'b0;
        #1;
        n_checks++; if ({bus.state_dbg, bus.RegWrite} !== {ST_LM, 1'b0}) begin n_fail++; $display("FAIL lm_exit_nowrite: got %h", {bus.state_dbg, bus.RegWrite}); end
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL lm_return: got %0d want %0d", bus.state_dbg, ST_FETCH); end
        bus.instr = 16'h7A00;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.mem_wr} !== {ST_SM, 1'b0}) begin n_fail++; $display("FAIL sm_empty: got %h", {bus.state_dbg, bus.mem_wr}); end
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL sm_empty_return: got %0d want %0d", bus.state_dbg, ST_FETCH); end
    endtask

    task automatic test_beq();
        bus.instr = 16'hC283; bus.zero = 1'b1;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.Aluop} !== {ST_BEQ, 2'b10}) begin n_fail++; $display("FAIL beq_sub: got %h", {bus.state_dbg, bus.Aluop}); end
        @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.RegWrite, bus.RegDst, bus.aluScrb} !== {ST_BTAKE, 1'b1, 2'd2, 2'd1}) begin n_fail++; $display("FAIL btake: got %h", {bus.state_dbg, bus.RegWrite, bus.RegDst, bus.aluScrb}); end
        @(negedge clk);
        bus.zero = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL beq_not_taken: got %0d want %0d", bus.state_dbg, ST_FETCH); end
    endtask

    task automatic test_jal();
        bus.instr = 16'h8E05;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.Aluop, bus.RegDst, bus.RegWrite} !== {ST_LINK, 2'b11, 2'd1, 1'b1}) begin n_fail++; $display("FAIL jal_link: got %h", {bus.state_dbg, bus.Aluop, bus.RegDst, bus.RegWrite}); end
        @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.RegDst, bus.MemtoReg} !== {ST_JAL, 2'd2, 2'd3}) begin n_fail++; $display("FAIL jal_jump: got %h", {bus.state_dbg, bus.RegDst, bus.MemtoReg}); end
        @(negedge clk);
    endtask

    task automatic test_halt();
        bus.instr = 16'hF000;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.illegal_op} !== {ST_HALT, 1'b1}) begin n_fail++; $display("FAIL halt_entry: got %h", {bus.state_dbg, bus.illegal_op}); end
        bus.instr = 16'h0A50;
        repeat (3) @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.illegal_op, bus.IrWrite} !== {ST_HALT, 1'b1, 1'b0}) begin n_fail++; $display("FAIL halt_sticky: got %h", {bus.state_dbg, bus.illegal_op, bus.IrWrite}); end
        apply_reset();
        n_checks++; if ({bus.state_dbg, bus.illegal_op} !== {ST_FETCH, 1'b0}) begin n_fail++; $display("FAIL halt_cleared: got %h", {bus.state_dbg, bus.illegal_op}); end
        bus.instr = 16'h0A53;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.illegal_op} !== {ST_HALT, 1'b1}) begin n_fail++; $display("FAIL cz11_halt: got %h", {bus.state_dbg, bus.illegal_op}); end
        apply_reset();
    endtask

    task automatic test_sw_reset();
        bus.instr = 16'h54C1;
        @(negedge clk); @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.regA_in, bus.aluScrb} !== {ST_ADDR, 1'b1, 2'd1}) begin n_fail++; $display("FAIL sw_addr: got %h", {bus.state_dbg, bus.regA_in, bus.aluScrb}); end
        @(negedge clk);
        n_checks++; if ({bus.state_dbg, bus.mem_wr, bus.B_C, bus.IorD} !== {ST_SW, 1'b1, 2'd3, 2'd1}) begin n_fail++; $display("FAIL sw_write: got %h", {bus.state_dbg, bus.mem_wr, bus.B_C, bus.IorD}); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({bus.state_dbg, bus.mem_wr} !== {ST_RESET, 1'b0}) begin n_fail++; $display("FAIL sw_async_abort: got %h", {bus.state_dbg, bus.mem_wr}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.state_dbg !== ST_FETCH) begin n_fail++; $display("FAIL sw_restart: got %0d want %0d", bus.state_dbg, ST_FETCH); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cond();
        test_lm();
        test_beq();
        test_jal();
        test_halt();
        test_sw_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
